// File: rtl/cpu_mem_pkg.sv
// Shared constants for the CPU-side RAM port: access encoding, FSM states
// and default bus widths.
package cpu_mem_pkg;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 32;

    // Wide enough for the largest legal WAIT_CYCLES-1 (15 - 1).
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick: a lone request wins outright,
// a tie goes to the port that was not granted last.
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic gnt_valid,
    output logic gnt_id
);

    always_comb begin
        gnt_valid = req0 | req1;
        if (req0 && req1) begin
            gnt_id = ~last_grant;
        end else begin
            gnt_id = req1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported RAM between instruction fetch (port 0) and
// the load/store unit (port 1); one access at a time, acked with a pulse.
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              rw0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              rw1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_enable,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    arb_state_t       state;
    arb_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic             last_grant;
    logic             gnt_valid;
    logic             gnt_id;

    rr_arb2 u_rr_arb2 (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (gnt_valid) state_next = ST_ACCESS;
            ST_ACCESS: if (cnt == '0) state_next = ST_DONE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // last_grant doubles as the owner of the access in flight, since it is
    // updated at the grant and not touched again until the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_enable <= 1'b0;
            mem_rw     <= RW_READ;
            mem_addr   <= '0;
            mem_din    <= '0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
            cnt        <= '0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt_valid) begin
                        mem_enable <= 1'b1;
                        mem_rw     <= gnt_id ? rw1 : rw0;
                        mem_addr   <= gnt_id ? addr1 : addr0;
                        mem_din    <= gnt_id ? wdata1 : wdata0;
                        cnt        <= CNT_W'(WAIT_CYCLES - 1);
                        last_grant <= gnt_id;
                    end
                end
                ST_ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        mem_enable <= 1'b0;
                        if (mem_rw == RW_READ) begin
                            if (last_grant) begin
                                rdata1 <= mem_dout;
                            end else begin
                                rdata0 <= mem_dout;
                            end
                        end
                        ack0 <= ~last_grant;
                        ack1 <= last_grant;
                    end
                end
                ST_DONE: begin
                    ack0 <= 1'b0;
                    ack1 <= 1'b0;
                end
                default: begin
                    ack0 <= 1'b0;
                    ack1 <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: three arbiter instances (WAIT_CYCLES 1, 3, 4), each wired
// to its own behavioural RAM model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst        [3];
    logic        req0       [3];
    logic        rw0        [3];
    logic [15:0] addr0      [3];
    logic [31:0] wdata0     [3];
    logic        req1       [3];
    logic        rw1        [3];
    logic [15:0] addr1      [3];
    logic [31:0] wdata1     [3];
    logic        ack0       [3];
    logic        ack1       [3];
    logic [31:0] rdata0     [3];
    logic [31:0] rdata1     [3];
    logic        mem_enable [3];
    logic        mem_rw     [3];
    logic [15:0] mem_addr   [3];
    logic [31:0] mem_din    [3];
    logic [31:0] mem_dout   [3];
    logic [31:0] ram        [3][64];

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int W = (g == 0) ? 1 : ((g == 1) ? 3 : 4);

        mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .WAIT_CYCLES(W)) u_dut (
            .clk        (clk),
            .rst        (rst[g]),
            .req0       (req0[g]),
            .rw0        (rw0[g]),
            .addr0      (addr0[g]),
            .wdata0     (wdata0[g]),
            .req1       (req1[g]),
            .rw1        (rw1[g]),
            .addr1      (addr1[g]),
            .wdata1     (wdata1[g]),
            .ack0       (ack0[g]),
            .ack1       (ack1[g]),
            .rdata0     (rdata0[g]),
            .rdata1     (rdata1[g]),
            .mem_enable (mem_enable[g]),
            .mem_rw     (mem_rw[g]),
            .mem_addr   (mem_addr[g]),
            .mem_din    (mem_din[g]),
            .mem_dout   (mem_dout[g])
        );

        always @(posedge clk) begin
            if (mem_enable[g] && (mem_rw[g] == 1'b0))
                ram[g][mem_addr[g][5:0]] <= mem_din[g];
        end

        assign mem_dout[g] = ram[g][mem_addr[g][5:0]];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        for (int d = 0; d < 3; d++) rst[d] = 1'b1;
        tick();
        tick();
        for (int d = 0; d < 3; d++) begin
            total++;
            if (mem_enable[d] !== 1'b0 || mem_rw[d] !== 1'b1 || mem_addr[d] !== 16'h0 || mem_din[d] !== 32'h0) begin
                $display("FAIL reset_mem[%0d]: got en=%b rw=%b addr=%h din=%h, want en=0 rw=1 addr=0 din=0",
                         d, mem_enable[d], mem_rw[d], mem_addr[d], mem_din[d]);
            end else passed++;
            total++;
            if (ack0[d] !== 1'b0 || ack1[d] !== 1'b0 || rdata0[d] !== 32'h0 || rdata1[d] !== 32'h0) begin
                $display("FAIL reset_port[%0d]: got ack=%b%b rdata0=%h rdata1=%h, want all 0",
                         d, ack0[d], ack1[d], rdata0[d], rdata1[d]);
            end else passed++;
        end
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;
        tick();
        tick();
        total++;
        if (mem_enable[0] !== 1'b0 || ack0[0] !== 1'b0 || ack1[0] !== 1'b0) begin
            $display("FAIL idle_quiet: got en=%b ack=%b%b, want 0 00", mem_enable[0], ack0[0], ack1[0]);
        end else passed++;
    endtask

    task automatic test_single_read;
        req0[0] = 1'b1; rw0[0] = 1'b1; addr0[0] = 16'd2;
        tick();
        total++;
        if (mem_enable[0] !== 1'b1 || mem_addr[0] !== 16'd2 || mem_rw[0] !== 1'b1 || ack0[0] !== 1'b0) begin
            $display("FAIL single_access: got en=%b addr=%h rw=%b ack0=%b, want 1 0002 1 0",
                     mem_enable[0], mem_addr[0], mem_rw[0], ack0[0]);
        end else passed++;
        tick();
        total++;
        if (ack0[0] !== 1'b1 || ack1[0] !== 1'b0 || rdata0[0] !== 32'hDEADBEEF || mem_enable[0] !== 1'b0) begin
            $display("FAIL single_ack: got ack=%b%b rdata0=%h en=%b, want ack0 rdata0=deadbeef en=0",
                     ack0[0], ack1[0], rdata0[0], mem_enable[0]);
        end else passed++;
        req0[0] = 1'b0;
        tick();
        total++;
        if (ack0[0] !== 1'b0 || rdata0[0] !== 32'hDEADBEEF) begin
            $display("FAIL single_hold: got ack0=%b rdata0=%h, want 0 deadbeef", ack0[0], rdata0[0]);
        end else passed++;
    endtask

    task automatic test_write_read;
        req1[0] = 1'b1; rw1[0] = 1'b0; addr1[0] = 16'd5; wdata1[0] = 32'h12345678;
        tick();
        total++;
        if (mem_enable[0] !== 1'b1 || mem_rw[0] !== 1'b0 || mem_addr[0] !== 16'd5 || mem_din[0] !== 32'h12345678) begin
            $display("FAIL write_access: got en=%b rw=%b addr=%h din=%h, want 1 0 0005 12345678",
                     mem_enable[0], mem_rw[0], mem_addr[0], mem_din[0]);
        end else passed++;
        tick();
        total++;
        if (ack1[0] !== 1'b1 || ack0[0] !== 1'b0 || rdata1[0] !== 32'h0) begin
            $display("FAIL write_ack: got ack=%b%b rdata1=%h, want ack1 only, rdata1=0",
                     ack0[0], ack1[0], rdata1[0]);
        end else passed++;
        rw1[0] = 1'b1;
        tick();
        tick();
        tick();
        total++;
        if (ack1[0] !== 1'b1 || rdata1[0] !== 32'h12345678 || rdata0[0] !== 32'hDEADBEEF) begin
            $display("FAIL readback: got ack1=%b rdata1=%h rdata0=%h, want 1 12345678 deadbeef",
                     ack1[0], rdata1[0], rdata0[0]);
        end else passed++;
        req1[0] = 1'b0;
        tick();
    endtask

    task automatic test_tie;
        int n0;
        int n1;
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        req0[0] = 1'b1; rw0[0] = 1'b1; addr0[0] = 16'd0;
        req1[0] = 1'b1; rw1[0] = 1'b1; addr1[0] = 16'd1;
        n0 = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (ack0[0] || ack1[0]) begin
                n0 = ack0[0] ? i : -i;
                break;
            end
        end
        req0[0] = 1'b0;
        n1 = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (ack1[0]) begin
                n1 = i;
                break;
            end
        end
        req1[0] = 1'b0;
        total++;
        if (n0 !== 2 || rdata0[0] !== 32'h10000000) begin
            $display("FAIL tie_first: got port0 ack at %0d rdata0=%h, want 2 10000000", n0, rdata0[0]);
        end else passed++;
        total++;
        if (n1 !== 3 || rdata1[0] !== 32'h10000001) begin
            $display("FAIL tie_second: got port1 ack %0d later rdata1=%h, want 3 10000001", n1, rdata1[0]);
        end else passed++;
        tick();
    endtask

    task automatic test_reset_mid;
        int first;
        int n;
        int stray;
        req0[1] = 1'b1; rw0[1] = 1'b1; addr0[1] = 16'd2;
        stray = 0;
        tick();
        tick();
        total++;
        if (mem_enable[1] !== 1'b1 || mem_addr[1] !== 16'd2) begin
            $display("FAIL mid_access: got en=%b addr=%h, want 1 0002", mem_enable[1], mem_addr[1]);
        end else passed++;
        rst[1] = 1'b1;
        tick();
        if (ack0[1] || ack1[1]) stray++;
        rst[1] = 1'b0;
        total++;
        if (mem_enable[1] !== 1'b0 || mem_addr[1] !== 16'h0 || rdata0[1] !== 32'h0) begin
            $display("FAIL mid_reset: got en=%b addr=%h rdata0=%h, want 0 0000 0",
                     mem_enable[1], mem_addr[1], rdata0[1]);
        end else passed++;
        req1[1] = 1'b1; rw1[1] = 1'b1; addr1[1] = 16'd4;
        first = -1;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (ack0[1] || ack1[1]) begin
                first = ack1[1] ? 1 : 0;
                n = i;
                break;
            end
        end
        req0[1] = 1'b0;
        total++;
        if (first !== 0 || n !== 4 || stray !== 0) begin
            $display("FAIL mid_regrant: got port=%0d after %0d cycles stray=%0d, want port 0 after 4, stray 0",
                     first, n, stray);
        end else passed++;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (ack1[1]) break;
        end
        req1[1] = 1'b0;
        tick();
    endtask

    task automatic test_contention;
        int acks;
        int both;
        int bad_run;
        int run;
        int last_cyc;
        req0[1] = 1'b1; rw0[1] = 1'b1; addr0[1] = 16'd3;
        req1[1] = 1'b1; rw1[1] = 1'b1; addr1[1] = 16'd4;
        acks = 0; both = 0; bad_run = 0; run = 0; last_cyc = 0;
        for (int cyc = 1; cyc <= 200 && acks < 8; cyc++) begin
            tick();
            if (ack0[1] && ack1[1]) both++;
            if (mem_enable[1]) run++;
            else if (run != 0) begin
                if (run != 3) bad_run++;
                run = 0;
            end
            if (ack0[1] || ack1[1]) begin
                total++;
                if (ack1[1] !== 1'(acks % 2)) begin
                    $display("FAIL order[%0d]: got port %0d, want port %0d", acks, ack1[1], acks % 2);
                end else passed++;
                total++;
                if ((ack1[1] && rdata1[1] !== 32'h10000004) || (ack0[1] && rdata0[1] !== 32'h10000003)) begin
                    $display("FAIL cont_data[%0d]: got rdata0=%h rdata1=%h, want 10000003/10000004",
                             acks, rdata0[1], rdata1[1]);
                end else passed++;
                if (acks > 0) begin
                    total++;
                    if (cyc - last_cyc !== 5) begin
                        $display("FAIL spacing[%0d]: got %0d cycles, want 5", acks, cyc - last_cyc);
                    end else passed++;
                end
                last_cyc = cyc;
                acks++;
                if (acks == 8) begin
                    req0[1] = 1'b0;
                    req1[1] = 1'b0;
                end
            end
        end
        req0[1] = 1'b0;
        req1[1] = 1'b0;
        total++;
        if (acks !== 8 || both !== 0 || bad_run !== 0) begin
            $display("FAIL contention: got acks=%0d both=%0d bad_enable_runs=%0d, want 8 0 0", acks, both, bad_run);
        end else passed++;
        tick();
        tick();
    endtask

    task automatic test_withdrawn;
        int en_cnt;
        int ack_cnt;
        int ack_at;
        req1[2] = 1'b1; rw1[2] = 1'b1; addr1[2] = 16'd2;
        tick();
        req1[2] = 1'b0;
        en_cnt = mem_enable[2] ? 1 : 0;
        ack_cnt = 0;
        ack_at = -1;
        for (int i = 2; i <= 20; i++) begin
            tick();
            if (mem_enable[2]) en_cnt++;
            if (ack1[2]) begin
                ack_cnt++;
                ack_at = i;
            end
        end
        total++;
        if (ack_cnt !== 1 || ack_at !== 5) begin
            $display("FAIL withdrawn_ack: got %0d acks, last at %0d, want 1 at 5", ack_cnt, ack_at);
        end else passed++;
        total++;
        if (en_cnt !== 4 || rdata1[2] !== 32'hDEADBEEF || ack0[2] !== 1'b0) begin
            $display("FAIL withdrawn_access: got enable cycles=%0d rdata1=%h ack0=%b, want 4 deadbeef 0",
                     en_cnt, rdata1[2], ack0[2]);
        end else passed++;
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 64; i++) ram[d][i] = 32'h10000000 + 32'(i);
            ram[d][2] = 32'hDEADBEEF;
            rst[d] = 1'b1;
            req0[d] = 1'b0; rw0[d] = 1'b1; addr0[d] = '0; wdata0[d] = '0;
            req1[d] = 1'b0; rw1[d] = 1'b1; addr1[d] = '0; wdata1[d] = '0;
        end
        test_reset();
        test_single_read();
        test_write_read();
        test_tie();
        test_reset_mid();
        test_contention();
        test_withdrawn();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
